// File: rtl/pulse_stretcher.sv
// Turns single-cycle request pulses into fixed-length high levels, each
// followed by a low gap; requests arriving mid-pulse wait in a saturating counter.
module pulse_stretcher #(
   parameter int DIV        = 50000,
   parameter int HIGH_TICKS = 100,
   parameter int GAP_TICKS  = 50,
   parameter int PEND_W     = 3
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              PULSO,
   output logic              SALIDA,
   output logic              BUSY,
   output logic [PEND_W-1:0] PEND,
   output logic              DROP
);

   localparam int DIV_W  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int TMAX   = (HIGH_TICKS > GAP_TICKS) ? HIGH_TICKS : GAP_TICKS;
   localparam int TCNT_W = $clog2(TMAX + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [TCNT_W-1:0] HIGH_LAST = TCNT_W'(HIGH_TICKS - 1);
   localparam logic [TCNT_W-1:0] GAP_LAST  = TCNT_W'(GAP_TICKS - 1);
   localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   logic [PEND_W-1:0]   pend_q, pend_d;
   logic                salida_q;
   logic                drop_q, drop_d;
   logic                tick;
   logic                dec;

   // Returns {drop, next_count}; simultaneous inc and dec cancel out.
   function automatic logic [PEND_W:0] pend_sat(input logic [PEND_W-1:0] p,
                                                input logic inc,
                                                input logic dn);
      logic [PEND_W:0] r;
      r = {1'b0, p};
      if (inc && !dn) begin
         if (p == PEND_MAX) r = {1'b1, p};
         else               r = {1'b0, p + 1'b1};
      end else if (dn && !inc) begin
         r = {1'b0, p - 1'b1};
      end
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      tcnt_d  = tcnt_q;
      dec     = 1'b0;
      tick    = (div_q == DIV_LAST);
      case (state_q)
         IDLE: begin
            div_d  = '0;
            tcnt_d = '0;
            if (pend_q != '0) begin
               state_d = HIGH;
               dec     = 1'b1;
            end
         end
         HIGH: begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
               if (tcnt_q == HIGH_LAST) begin
                  state_d = GAP;
                  tcnt_d  = '0;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
         GAP: begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
               if (tcnt_q == GAP_LAST) begin
                  state_d = IDLE;
                  tcnt_d  = '0;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            div_d   = '0;
            tcnt_d  = '0;
         end
      endcase
      {drop_d, pend_d} = pend_sat(pend_q, PULSO, dec);
   end

   // Output level is registered from the next state so it tracks HIGH exactly.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= IDLE;
         div_q    <= '0;
         tcnt_q   <= '0;
         pend_q   <= '0;
         salida_q <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         tcnt_q   <= tcnt_d;
         pend_q   <= pend_d;
         salida_q <= (state_d == HIGH);
         drop_q   <= drop_d;
      end
   end

   assign SALIDA = salida_q;
   assign PEND   = pend_q;
   assign DROP   = drop_q;
   assign BUSY   = (state_q != IDLE) || (pend_q != '0);

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboarded bench for pulse_stretcher: stimulus queues expected output
// pulses (rise cycle, width); a monitor measures SALIDA and compares.
module tb_pulse_stretcher;

   localparam int DIV = 4;
   localparam int HT  = 3;
   localparam int GT  = 2;
   localparam int PW  = 2;
   localparam int HIGH_LEN = HT * DIV;
   localparam int PERIOD   = (HT + GT) * DIV + 1;

   logic          CLK   = 1'b0;
   logic          RESET = 1'b0;
   logic          PULSO = 1'b0;
   logic          SALIDA;
   logic          BUSY;
   logic [PW-1:0] PEND;
   logic          DROP;

   pulse_stretcher #(.DIV(DIV), .HIGH_TICKS(HT), .GAP_TICKS(GT), .PEND_W(PW)) dut (
      .CLK(CLK), .RESET(RESET), .PULSO(PULSO),
      .SALIDA(SALIDA), .BUSY(BUSY), .PEND(PEND), .DROP(DROP)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int rise;
      int len;
   } exp_t;

   exp_t sb[$];
   int   n_cmp    = 0;
   int   n_fail   = 0;
   int   drop_cnt = 0;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push(input int rise, input int len);
      exp_t e;
      e.rise = rise;
      e.len  = len;
      sb.push_back(e);
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge CLK);
   endtask

   task automatic req(input int n);
      PULSO = 1'b1;
      repeat (n) @(negedge CLK);
      PULSO = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while ((BUSY || SALIDA) && k < 400) begin
         @(negedge CLK);
         k++;
      end
      check({name, "_idle_timeout"}, int'(BUSY || SALIDA), 0);
      repeat (3) @(negedge CLK);
      check({name, "_sb_drained"}, sb.size(), 0);
   endtask

   // Monitor: measures each SALIDA high run and checks it against the queue.
   initial begin
      bit   in_pulse;
      int   rise;
      int   len;
      exp_t e;
      in_pulse = 0;
      rise     = 0;
      len      = 0;
      forever begin
         @(negedge CLK);
         if (SALIDA) begin
            if (!in_pulse) begin
               in_pulse = 1;
               rise     = cyc;
               len      = 0;
            end
            len++;
         end else if (in_pulse) begin
            in_pulse = 0;
            if (sb.size() == 0) begin
               check("unexpected_pulse_rise", rise, -1);
            end else begin
               e = sb.pop_front();
               check("pulse_rise", rise, e.rise);
               check("pulse_len", len, e.len);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge CLK);
         if (DROP) drop_cnt++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int d0;

      // Reset held with PULSO toggling: every output stays low.
      repeat (10) begin
         @(negedge CLK);
         PULSO = ~PULSO;
         #1;
         check("reset_hold", int'({SALIDA, BUSY, PEND, DROP}), 0);
      end
      @(negedge CLK);
      PULSO = 1'b0;
      RESET = 1'b1;
      repeat (2) @(negedge CLK);

      // Single request: latency, width, gap, BUSY fall.
      c = cyc;
      push(c + 2, HIGH_LEN);
      req(1);
      check("single_pend", int'(PEND), 1);
      wait_to(c + 21);
      check("single_busy_gap", int'(BUSY), 1);
      wait_to(c + 22);
      check("single_busy_idle", int'(BUSY), 0);
      wait_idle("single");

      // Queueing: three requests two cycles apart.
      c = cyc;
      push(c + 2, HIGH_LEN);
      push(c + 2 + PERIOD, HIGH_LEN);
      push(c + 2 + 2 * PERIOD, HIGH_LEN);
      req(1);
      wait_to(c + 2);
      req(1);
      wait_to(c + 4);
      req(1);
      check("queue_pend2", int'(PEND), 2);
      wait_to(c + 2 + PERIOD);
      check("queue_pend1", int'(PEND), 1);
      wait_to(c + 2 + 2 * PERIOD);
      check("queue_pend0", int'(PEND), 0);
      wait_idle("queue");

      // Saturation: five requests during HIGH with PEND at 0.
      c  = cyc;
      d0 = drop_cnt;
      for (int i = 0; i < 4; i++) push(c + 2 + i * PERIOD, HIGH_LEN);
      req(1);
      for (int i = 0; i < 5; i++) begin
         wait_to(c + 3 + 2 * i);
         req(1);
      end
      wait_to(c + 8);
      check("sat_pend_early", int'(PEND), 3);
      wait_to(c + 14);
      check("sat_pend", int'(PEND), 3);
      check("sat_drops", drop_cnt - d0, 2);
      wait_idle("sat");

      // Request on the exact IDLE->HIGH transition cycle.
      c  = cyc;
      d0 = drop_cnt;
      push(c + 2, HIGH_LEN);
      push(c + 2 + PERIOD, HIGH_LEN);
      req(2);
      check("simul_pend", int'(PEND), 1);
      check("simul_high", int'(SALIDA), 1);
      wait_idle("simul");
      check("simul_drops", drop_cnt - d0, 0);

      // Asynchronous reset on the fifth cycle of a high level with PEND=2.
      c = cyc;
      push(c + 2, 5);
      req(1);
      wait_to(c + 3);
      req(1);
      wait_to(c + 5);
      req(1);
      check("rst_pend_before", int'(PEND), 2);
      check("rst_high_before", int'(SALIDA), 1);
      #1;
      RESET = 1'b0;
      #1;
      check("rst_async_salida", int'(SALIDA), 0);
      check("rst_async_pend", int'(PEND), 0);
      check("rst_async_busy", int'(BUSY), 0);
      repeat (3) @(negedge CLK);
      RESET = 1'b1;
      repeat (60) @(negedge CLK);
      check("rst_no_more_busy", int'(BUSY), 0);
      check("rst_sb_drained", sb.size(), 0);

      // Wide PULSO: three consecutive high cycles from IDLE.
      c = cyc;
      push(c + 2, HIGH_LEN);
      push(c + 2 + PERIOD, HIGH_LEN);
      push(c + 2 + 2 * PERIOD, HIGH_LEN);
      req(3);
      check("wide_pend", int'(PEND), 2);
      wait_idle("wide");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Consumer end of the key-pulse path: accepts single-cycle request pulses, as produced by the key debounce/edge-detect stage, and turns each one into a human-visible fixed-length high level on an indicator output. Each high level is followed by a mandatory low gap. Requests that arrive while an output pulse is in progress are queued in a saturating pending counter, so no press is lost until the queue fills. Sits between the key pulse generator and board LEDs/external logic needing level-type strobes.

## Interface
- DIV, 50000: CLK cycles per internal tick; ≥2
- HIGH_TICKS, 100: ticks SALIDA stays high per request; ≥1
- GAP_TICKS, 50: ticks SALIDA stays low after each high pulse; ≥1
- PEND_W, 3: width of pending-request counter; max queue = 2^PEND_W−1
- CLK  in  1  single clock, all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- PULSO  in  1  request; each CLK cycle it is high counts as one request
- SALIDA  out  1  stretched output level, registered
- BUSY  out  1  high when state≠IDLE or PEND≠0, registered-derived
- PEND  out  PEND_W  pending request count
- DROP  out  1  one-cycle strobe: request lost to saturation

## Operation
- Reset (RESET=0, asynchronous): state=IDLE, tick divider=0, tick counter=0, PEND=0, SALIDA=0, BUSY=0, DROP=0. Held for as long as RESET=0; release takes effect on the next CLK edge.
- FSM states:
  - IDLE: SALIDA=0. If PEND≠0, go to HIGH and consume one request.
  - HIGH: SALIDA=1. After HIGH_TICKS ticks, go to GAP.
  - GAP: SALIDA=0. After GAP_TICKS ticks, go to IDLE.
- Divider: counts 0..DIV−1. The tick fires on the cycle the count equals DIV−1, then the count wraps to 0.
  - Divider and tick counter clear to 0 on every entry to HIGH or GAP, so durations are exact, not tick-aligned.
- Pending counter update per cycle (inc = PULSO; dec = IDLE→HIGH transition this cycle):
  - inc & dec: PEND unchanged.
  - inc only, PEND<max: PEND+1.
  - inc only, PEND=max: PEND unchanged, DROP=1 for that cycle.
  - dec only: PEND−1.
  - PEND never underflows; dec requires PEND≠0.
- PULSO high for k consecutive cycles counts as k requests. The upstream stage guarantees single-cycle pulses.
- IDLE sees only the registered PEND, so a request arriving in the same cycle is not consumed until the next cycle.

## Timing
- PULSO high at edge n → PEND=1 after edge n → FSM enters HIGH at edge n+1. SALIDA rises 2 cycles after the request edge.
- SALIDA high for exactly HIGH_TICKS·DIV cycles, then low for exactly GAP_TICKS·DIV cycles in GAP.
- With PEND≠0 at the end of GAP: IDLE lasts 1 cycle, then HIGH again.
  - Back-to-back period = (HIGH_TICKS+GAP_TICKS)·DIV+1 cycles.
- DROP asserts in the same cycle after the edge where saturation was detected. Width is 1 cycle per dropped request.
- BUSY falls in the cycle the FSM returns to IDLE with PEND=0.
- Reset mid-HIGH: SALIDA drops asynchronously. Queued requests are discarded.

## Test plan
Parameters for all scenarios: DIV=4, HIGH_TICKS=3, GAP_TICKS=2, PEND_W=2.

- Reset: hold RESET=0 with PULSO toggling → SALIDA=0, PEND=0, BUSY=0, DROP=0 throughout. Release, one PULSO → SALIDA rises 2 cycles later, high exactly 12 cycles, low 8 cycles in GAP, BUSY low afterwards.
- Queueing: 3 PULSO pulses 2 cycles apart → PEND reaches 2 (one already consumed) → three SALIDA pulses of 12 cycles, separated by 9 low cycles (8 GAP + 1 IDLE), PEND decrementing 2→1→0.
- Saturation: 5 single-cycle pulses while in HIGH, with PEND=0 at start → PEND saturates at 3, DROP strobes twice, exactly 3 further SALIDA pulses follow.
- Simultaneous: PULSO on the exact cycle of the IDLE→HIGH transition with PEND=1 → PEND stays 1, no DROP, two SALIDA pulses total.
- Async reset mid-HIGH, at cycle 5 of the high level, with PEND=2 → SALIDA=0 and PEND=0 immediately without a CLK edge. After release, no further pulses without new PULSO.
- Wide PULSO: held 3 cycles from IDLE → counts as 3 requests, exactly 3 SALIDA pulses.
